mem_function_responder: RTL and testbench
=========================================

Name: mem_function_responder

Overview:
- Memory-side responder for the processor's memory stage. The control path issues read/write requests through MEM_r_w_z_z, with the address and store data taken from RZ and RM.
- The block services each request from an internal word-addressed data store after a programmable number of wait states.
- It completes each access with a one-cycle MFC (memory-function-complete) pulse, then waits for the request to be released before it accepts another.

Parameters:
- DEPTH, 256: number of 32-bit words in the store (power of two, 4..4096).
- WAIT_STATES, 2: cycles spent in WAIT before completion (0..15; 0 means no WAIT cycles).
- ADDR_W, 32: byte-address width.

Ports:
- Clock  in  1  rising-edge system clock.
- Reset_n  in  1  asynchronous active-low reset.
- MEM_r_w_z_z  in  2  request: 2'b10 read, 2'b01 write, 2'b00 idle, 2'b11 illegal.
- Mem_Address  in  ADDR_W  byte address (from MuxMA).
- Mem_DataIn  in  32  store data (from RM).
- Mem_DataOut  out  32  load data (to MuxY); held until the next completed read.
- MFC  out  1  one-cycle completion pulse.
- Busy  out  1  high in every state except IDLE.
- Access_Error  out  1  one-cycle pulse on an illegal, misaligned or out-of-range request.

Behaviour:
Reset and clocking:
- One clock; reset is asynchronous and active-low (Clock, Reset_n).
- Reset drives: state=IDLE, Mem_DataOut=0, MFC=0, Busy=0, Access_Error=0, wait counter=0.
- The storage array is not reset.
- Reset asserted mid-operation aborts the access. A write not yet committed is lost.

States: IDLE, WAIT, DONE, RELEASE.

IDLE:
- Each cycle, sample MEM_r_w_z_z.
- On 2'b10 or 2'b01, latch op, word index = Mem_Address[log2(DEPTH)+1:2], and Mem_DataIn.
- If the request is legal, go to WAIT (counter=WAIT_STATES), or straight to DONE when WAIT_STATES=0.
- Illegal request (2'b11, Mem_Address[1:0]!=0, or Mem_Address >= 4*DEPTH):
  - pulse Access_Error next cycle;
  - go to RELEASE with no MFC;
  - no store update.

WAIT:
- Decrement the counter each cycle; move to DONE when the counter reaches 1.
- Total cycles from request sample to MFC = WAIT_STATES+1.
- Request inputs are ignored while in WAIT; the latched values are used.
- If MEM_r_w_z_z returns to 2'b00 during WAIT, abort to IDLE: no MFC, no write.

DONE (exactly one cycle):
- MFC=1.
- Write: the store commits on the clock edge entering DONE.
- Read: Mem_DataOut is loaded on the clock edge entering DONE, so it is valid while MFC=1.
- Next state is RELEASE.

RELEASE:
- Stay until MEM_r_w_z_z==2'b00, then go to IDLE.
- This prevents a held request from being serviced twice.
- If the request is already 2'b00 in the DONE cycle, RELEASE lasts one cycle.

Data rules:
- Read-after-write to the same word, issued as the next request, returns the new data.
- No byte lanes; writes are full 32-bit words.
- MFC and Access_Error are never high in the same cycle.
- Busy=0 only in IDLE.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, WAIT=2'd1, DONE=2'd2, RELEASE=2'd3) and request codes (MEM_IDLE=2'b00, MEM_WRITE=2'b01, MEM_READ=2'b10). The StageTracker and SelectController drivers of MEM_r_w_z_z use the same request constants.
- One natural sub-module, mem_word_store: the synchronous single-port DEPTH x 32 array with write enable and registered read.
- The FSM, wait counter and error checks stay in mem_function_responder.

Test Plan:
1. Write then read, WAIT_STATES=2:
   - stimulus: write 0xDEADBEEF to addr 0x10 → MFC exactly 3 cycles after the request is sampled;
   - stimulus: drop the request, then read 0x10 → Mem_DataOut=0xDEADBEEF in the MFC cycle.
2. Held request:
   - stimulus: keep 2'b10 asserted 6 cycles after MFC → a single MFC pulse, Busy=1 throughout, and IDLE only after 2'b00.
3. Errors, each a one-cycle Access_Error pulse with no MFC and the store unchanged:
   - request 2'b11;
   - addr 0x13 (misaligned);
   - addr 4*DEPTH (out of range).
4. Abort:
   - stimulus: write 0x1234 to addr 0x20, drop the request during WAIT → no MFC, and a later read of 0x20 returns the old value.
5. Reset mid-access:
   - stimulus: Reset_n low during WAIT of a write → MFC=0, Busy=0 and Mem_DataOut=0 immediately (asynchronous); the write is not committed.
6. WAIT_STATES=0:
   - stimulus: read addr 0x0 → MFC in the cycle after the request is sampled;
   - stimulus: back-to-back read/write pairs separated by one idle cycle → all complete correctly.

Source files
------------

// File: rtl/mem_function_responder_pkg.sv
// Shared encodings for the memory-stage responder: FSM states and the
// MEM_r_w_z_z request codes also driven by the stage tracker and select controller.
package mem_function_responder_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DONE    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        MEM_IDLE    = 2'b00,
        MEM_WRITE   = 2'b01,
        MEM_READ    = 2'b10,
        MEM_ILLEGAL = 2'b11
    } mem_req_t;

endpackage

// File: rtl/mem_word_store.sv
// Single-port DEPTH x 32 word store: synchronous write, registered read that
// holds its value until the next read strobe.
module mem_word_store
    import mem_function_responder_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic              re,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    // NOTE: the array has no reset so it maps onto plain RAM; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_function_responder.sv
// Memory-stage responder: accepts a read/write request, waits WAIT_STATES cycles,
// pulses MFC, then holds in RELEASE until the requester drops the request.
module mem_function_responder
    import mem_function_responder_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 2,
    parameter int ADDR_W      = 32
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic [1:0]        MEM_r_w_z_z,
    input  logic [ADDR_W-1:0] Mem_Address,
    input  logic [WORD_W-1:0] Mem_DataIn,
    output logic [WORD_W-1:0] Mem_DataOut,
    output logic              MFC,
    output logic              Busy,
    output logic              Access_Error
);

    localparam int         AW = $clog2(DEPTH);
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                op_write_q;
    logic [AW-1:0]       idx_q;
    logic [WORD_W-1:0]   wdata_q;
    logic                err_q;

    logic                req_active, illegal, commit, cmd_write;
    logic [AW-1:0]       cmd_idx;
    logic [WORD_W-1:0]   cmd_wdata;

    assign req_active = (MEM_r_w_z_z != MEM_IDLE);
    assign illegal    = (MEM_r_w_z_z == MEM_ILLEGAL)
                     || (Mem_Address[1:0] != 2'b00)
                     || ((Mem_Address >> (AW + 2)) != '0);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_active) begin
                    if (illegal) begin
                        state_d = RELEASE;
                    end else if (WAIT_STATES == 0) begin
                        state_d = DONE;
                        commit  = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WS;
                    end
                end
            end
            WAIT: begin
                if (!req_active) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q <= 4'd1) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE:    state_d = RELEASE;
            RELEASE: if (!req_active) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // With zero wait states the commit happens on the sampling edge, so use live inputs.
    assign cmd_write = (state_q == IDLE) ? (MEM_r_w_z_z == MEM_WRITE) : op_write_q;
    assign cmd_idx   = (state_q == IDLE) ? Mem_Address[AW+1:2] : idx_q;
    assign cmd_wdata = (state_q == IDLE) ? Mem_DataIn : wdata_q;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_write_q <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= (state_q == IDLE) && req_active && illegal;
            if (state_q == IDLE && req_active) begin
                op_write_q <= (MEM_r_w_z_z == MEM_WRITE);
                idx_q      <= Mem_Address[AW+1:2];
                wdata_q    <= Mem_DataIn;
            end
        end
    end

    mem_word_store #(.DEPTH(DEPTH), .AW(AW)) u_store (
        .clk   (Clock),
        .rst_n (Reset_n),
        .we    (commit && cmd_write),
        .re    (commit && !cmd_write),
        .addr  (cmd_idx),
        .wdata (cmd_wdata),
        .rdata (Mem_DataOut)
    );

    assign MFC          = (state_q == DONE);
    assign Busy         = (state_q != IDLE);
    assign Access_Error = err_q;

endmodule

// File: tb/tb_mem_function_responder.sv
// Bench for mem_function_responder: a WAIT_STATES=2 and a WAIT_STATES=0 instance
// share one stimulus stream and are compared every cycle against a request-level model.
module tb_mem_function_responder;

    logic        Clock = 1'b0;
    logic        Reset_n = 1'b1;
    logic [1:0]  req = 2'b00;
    logic [31:0] addr = '0;
    logic [31:0] din = '0;

    logic [31:0] dout2, dout0;
    logic        mfc2, mfc0, busy2, busy0, err2, err0;

    int n_total = 0;
    int n_bad   = 0;

    always #5 Clock = ~Clock;

    mem_function_responder #(.DEPTH(256), .WAIT_STATES(2), .ADDR_W(32)) dut_ws2 (
        .Clock(Clock), .Reset_n(Reset_n), .MEM_r_w_z_z(req), .Mem_Address(addr),
        .Mem_DataIn(din), .Mem_DataOut(dout2), .MFC(mfc2), .Busy(busy2), .Access_Error(err2)
    );

    mem_function_responder #(.DEPTH(256), .WAIT_STATES(0), .ADDR_W(32)) dut_ws0 (
        .Clock(Clock), .Reset_n(Reset_n), .MEM_r_w_z_z(req), .Mem_Address(addr),
        .Mem_DataIn(din), .Mem_DataOut(dout0), .MFC(mfc0), .Busy(busy0), .Access_Error(err0)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- request-level reference model (index 0: ws=2, 1: ws=0)
    int          ws_of [2] = '{2, 0};
    bit          pend [2];   // accepted, still counting down to completion
    bit          hold [2];   // completed or rejected, waiting for the request to drop
    bit          skip [2];   // the completion cycle itself never releases
    int          left [2];
    bit          wr_l [2];
    int          idx_l [2];
    logic [31:0] dat_l [2];
    logic [31:0] mm [2][256];
    logic [31:0] e_dout [2];
    bit          e_mfc [2], e_busy [2], e_err [2];

    function automatic bit is_bad(input logic [1:0] r, input logic [31:0] a);
        return (r == 2'b11) || (a % 4 != 0) || (a >= 32'd1024);
    endfunction

    task automatic finish_access(input int k);
        pend[k] = 0;
        if (wr_l[k]) mm[k][idx_l[k]] = dat_l[k];
        else         e_dout[k] = mm[k][idx_l[k]];
        e_mfc[k] = 1;
        hold[k]  = 1;
        skip[k]  = 1;
    endtask

    task automatic model_step(input int k, input logic rn, input logic [1:0] r,
                              input logic [31:0] a, input logic [31:0] d);
        bit was_free;
        e_mfc[k] = 0;
        e_err[k] = 0;
        if (!rn) begin
            pend[k] = 0; hold[k] = 0; skip[k] = 0;
            e_dout[k] = '0; e_busy[k] = 0;
            return;
        end
        was_free = !pend[k] && !hold[k];
        if (hold[k]) begin
            if (skip[k]) skip[k] = 0;
            else if (r == 2'b00) hold[k] = 0;
        end
        if (pend[k]) begin
            if (r == 2'b00) pend[k] = 0;
            else begin
                left[k]--;
                if (left[k] == 0) finish_access(k);
            end
        end else if (was_free && r != 2'b00) begin
            if (is_bad(r, a)) begin
                e_err[k] = 1; hold[k] = 1; skip[k] = 0;
            end else begin
                wr_l[k] = (r == 2'b01); idx_l[k] = int'(a / 4); dat_l[k] = d;
                if (ws_of[k] == 0) finish_access(k);
                else begin pend[k] = 1; left[k] = ws_of[k]; end
            end
        end
        e_busy[k] = pend[k] || hold[k];
    endtask

    always @(posedge Clock) begin
        model_step(0, Reset_n, req, addr, din);
        model_step(1, Reset_n, req, addr, din);
        #1;
        check("mfc_ws2",  32'(mfc2),  32'(e_mfc[0]));
        check("busy_ws2", 32'(busy2), 32'(e_busy[0]));
        check("err_ws2",  32'(err2),  32'(e_err[0]));
        check("dout_ws2", dout2,      e_dout[0]);
        check("mfc_ws0",  32'(mfc0),  32'(e_mfc[1]));
        check("busy_ws0", 32'(busy0), 32'(e_busy[1]));
        check("err_ws0",  32'(err0),  32'(e_err[1]));
        check("dout_ws0", dout0,      e_dout[1]);
    end

    // ---------------- stimulus helpers (always entered and left at a negedge)
    function automatic logic [31:0] pre(input int i);
        return 32'hC0DE_0000 + 32'(i);
    endfunction

    task automatic go(input logic [1:0] r, input logic [31:0] a, input logic [31:0] d);
        req = r; addr = a; din = d;
    endtask

    task automatic watch(input int n, output logic [15:0] m2, output logic [15:0] m0,
                         output logic [15:0] b2, output logic [15:0] e2, output logic [15:0] e0,
                         output logic [31:0] d2, output logic [31:0] d0);
        m2 = '0; m0 = '0; b2 = '0; e2 = '0; e0 = '0; d2 = '0; d0 = '0;
        for (int i = 0; i < n; i++) begin
            @(posedge Clock); #1;
            m2[i] = mfc2; m0[i] = mfc0; b2[i] = busy2; e2[i] = err2; e0[i] = err0;
            if (mfc2) d2 = dout2;
            if (mfc0) d0 = dout0;
        end
        @(negedge Clock);
    endtask

    logic [15:0] m2, m0, b2, e2, e0, x2, x0;
    logic [31:0] d2, d0, xd2, xd0;

    task automatic rd(input logic [31:0] a, output logic [31:0] r2, output logic [31:0] r0);
        go(2'b10, a, '0);
        watch(4, m2, m0, b2, e2, e0, r2, r0);
        req = 2'b00;
        watch(1, x2, x0, b2, e2, e0, xd2, xd0);
    endtask

    initial begin
        logic [31:0] wd;
        int sel, hold_n, gap_n;
        logic [1:0]  r;
        logic [31:0] a;

        #3 Reset_n = 1'b0;
        @(negedge Clock);
        check("reset_mfc",  32'(mfc2),  32'd0);
        check("reset_busy", 32'(busy2), 32'd0);
        check("reset_err",  32'(err2),  32'd0);
        check("reset_dout", dout2,      32'd0);
        @(negedge Clock);
        Reset_n = 1'b1;
        @(negedge Clock);

        for (int i = 0; i < 32; i++) begin
            go(2'b01, 32'(i * 4), pre(i));
            watch(4, m2, m0, b2, e2, e0, d2, d0);
            req = 2'b00;
            watch(1, m2, m0, b2, e2, e0, d2, d0);
        end

        // write then read with 2 wait states; the zero-wait twin completes one cycle after sampling
        go(2'b01, 32'h10, 32'hDEADBEEF);
        watch(4, m2, m0, b2, e2, e0, d2, d0);
        check("wr_mfc_timing_ws2", 32'(m2[3:0]), 32'h4);
        check("wr_mfc_timing_ws0", 32'(m0[3:0]), 32'h1);
        req = 2'b00;
        watch(1, m2, m0, b2, e2, e0, d2, d0);
        go(2'b10, 32'h10, '0);
        watch(4, m2, m0, b2, e2, e0, d2, d0);
        check("rd_mfc_timing_ws2", 32'(m2[3:0]), 32'h4);
        check("rd_data_ws2", d2, 32'hDEADBEEF);
        check("rd_data_ws0", d0, 32'hDEADBEEF);
        req = 2'b00;
        watch(1, m2, m0, b2, e2, e0, d2, d0);

        // held request: one MFC, busy throughout, idle only once the request drops
        go(2'b10, 32'h10, '0);
        watch(9, m2, m0, b2, e2, e0, d2, d0);
        check("held_single_mfc", 32'(m2[8:0]), 32'h004);
        check("held_busy",       32'(b2[8:0]), 32'h1FF);
        req = 2'b00;
        watch(2, m2, m0, b2, e2, e0, d2, d0);
        check("held_release_idle", 32'(b2[1:0]), 32'h0);

        // illegal code, misaligned write, out-of-range write
        go(2'b11, 32'h10, 32'h0BAD0001);
        watch(3, m2, m0, b2, e2, e0, d2, d0);
        check("err_code_pulse", 32'(e2[2:0]), 32'h1);
        check("err_code_nomfc", 32'(m2[2:0] | m0[2:0]), 32'h0);
        req = 2'b00;
        watch(2, m2, m0, b2, e2, e0, d2, d0);
        go(2'b01, 32'h13, 32'h0BAD0002);
        watch(3, m2, m0, b2, e2, e0, d2, d0);
        check("err_misaligned_pulse_ws0", 32'(e0[2:0]), 32'h1);
        check("err_misaligned_nomfc", 32'(m2[2:0] | m0[2:0]), 32'h0);
        req = 2'b00;
        watch(2, m2, m0, b2, e2, e0, d2, d0);
        go(2'b01, 32'h400, 32'h0BAD0003);
        watch(3, m2, m0, b2, e2, e0, d2, d0);
        check("err_range_pulse", 32'(e2[2:0]), 32'h1);
        req = 2'b00;
        watch(2, m2, m0, b2, e2, e0, d2, d0);
        check("err_release_idle", 32'(b2[1:0]), 32'h0);
        rd(32'h10, d2, d0);
        check("err_store_kept_0x10", d2, 32'hDEADBEEF);
        rd(32'h0, d2, d0);
        check("err_store_kept_0x0", d2, pre(0));

        // abort during WAIT: the ws=2 instance drops the write, the ws=0 one already committed it
        go(2'b01, 32'h20, 32'h1234);
        watch(2, m2, m0, b2, e2, e0, d2, d0);
        req = 2'b00;
        watch(3, x2, x0, b2, e2, e0, d2, d0);
        check("abort_nomfc", 32'({x2[2:0], m2[1:0]}), 32'h0);
        rd(32'h20, d2, d0);
        check("abort_old_data_ws2", d2, pre(8));
        check("abort_committed_ws0", d0, 32'h1234);

        // asynchronous reset in the middle of a write's wait states
        go(2'b01, 32'h24, 32'h5555);
        watch(2, m2, m0, b2, e2, e0, d2, d0);
        #2 Reset_n = 1'b0;
        #1;
        check("rst_async_mfc",  32'(mfc2),  32'd0);
        check("rst_async_busy", 32'({busy2, busy0}), 32'd0);
        check("rst_async_dout", dout2,      32'd0);
        req = 2'b00;
        @(negedge Clock);
        @(negedge Clock);
        Reset_n = 1'b1;
        @(negedge Clock);
        rd(32'h24, d2, d0);
        check("rst_write_lost", d2, pre(9));
        check("rst_ws0_committed", d0, 32'h5555);

        // zero wait states: read address 0, then back-to-back pairs with one idle cycle
        go(2'b10, 32'h0, '0);
        watch(2, m2, m0, b2, e2, e0, d2, d0);
        check("ws0_read_timing", 32'(m0[1:0]), 32'h1);
        check("ws0_read_data", d0, pre(0));
        req = 2'b00;
        watch(1, m2, m0, b2, e2, e0, d2, d0);
        for (int j = 0; j < 4; j++) begin
            wd = $urandom;
            go(2'b01, 32'((16 + j) * 4), wd);
            watch(2, m2, m0, b2, e2, e0, d2, d0);
            check("b2b_wr_mfc", 32'(m0[1:0]), 32'h1);
            req = 2'b00;
            watch(1, m2, m0, b2, e2, e0, d2, d0);
            go(2'b10, 32'((16 + j) * 4), '0);
            watch(2, m2, m0, b2, e2, e0, d2, d0);
            check("b2b_rd_mfc", 32'(m0[1:0]), 32'h1);
            check("b2b_rd_data", d0, wd);
            req = 2'b00;
            watch(1, m2, m0, b2, e2, e0, d2, d0);
        end

        // random traffic, inputs scrambled while a request is held
        for (int t = 0; t < 400; t++) begin
            sel = $urandom_range(0, 15);
            if (sel == 0) begin
                r = 2'b11; a = 32'($urandom_range(0, 31) * 4);
            end else if (sel == 1) begin
                r = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
                a = 32'($urandom_range(0, 31) * 4 + $urandom_range(1, 3));
            end else if (sel == 2) begin
                r = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
                a = 32'($urandom_range(256, 4000) * 4);
            end else begin
                r = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
                a = 32'($urandom_range(0, 31) * 4);
            end
            hold_n = $urandom_range(1, 7);
            gap_n  = $urandom_range(0, 3);
            go(r, a, $urandom);
            repeat (hold_n) begin
                @(negedge Clock);
                addr = $urandom;
                din  = $urandom;
            end
            req = 2'b00;
            repeat (gap_n) @(negedge Clock);
        end

        req = 2'b00;
        repeat (10) @(negedge Clock);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
